// File: rtl/mul_div_unit_pkg.sv
// Shared definitions for the RV32M multiply/divide unit: funct3 codes,
// divider FSM states and small funct3 decode helpers.
package mul_div_unit_pkg;

   localparam logic [2:0] FUNCT3_MUL    = 3'b000;
   localparam logic [2:0] FUNCT3_MULH   = 3'b001;
   localparam logic [2:0] FUNCT3_MULHSU = 3'b010;
   localparam logic [2:0] FUNCT3_MULHU  = 3'b011;
   localparam logic [2:0] FUNCT3_DIV    = 3'b100;
   localparam logic [2:0] FUNCT3_DIVU   = 3'b101;
   localparam logic [2:0] FUNCT3_REM    = 3'b110;
   localparam logic [2:0] FUNCT3_REMU   = 3'b111;

   typedef enum logic [1:0] {
      DIV_IDLE,
      DIV_RUN,
      DIV_DONE
   } div_state_t;

   function automatic logic is_div_op(input logic [2:0] f3);
      return f3[2];
   endfunction

   // DIV and REM are the signed divide ops; bit 0 marks the unsigned variants.
   function automatic logic is_signed_div(input logic [2:0] f3);
      return f3[2] && !f3[0];
   endfunction

   function automatic logic is_rem_op(input logic [2:0] f3);
      return f3[2] && f3[1];
   endfunction

endpackage

// File: rtl/mul_div_unit_div_iter.sv
// Unsigned restoring divider: loaded on start, retires DIV_BITS quotient bits
// per enabled cycle; last is high during the cycle of the final step.
module div_iter #(
   parameter int XLEN     = 32,
   parameter int DIV_BITS = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            rdy,
   input  logic            flush,
   input  logic            start,
   input  logic [XLEN-1:0] dividend,
   input  logic [XLEN-1:0] divisor,
   output logic            last,
   output logic [XLEN-1:0] quotient,
   output logic [XLEN-1:0] remainder
);

   localparam int ITERS = XLEN / DIV_BITS;
   localparam int CW    = $clog2(ITERS + 1);

   logic [CW-1:0]   count;
   logic [XLEN-1:0] quo, rem, dsr;
   logic [XLEN-1:0] quo_next, rem_next;
   logic [XLEN:0]   shifted, diff;

   // The dividend shifts out of the top of quo while quotient bits enter at
   // the bottom; a borrow in diff[XLEN] means the trial subtract is undone.
   always_comb begin
      quo_next = quo;
      rem_next = rem;
      shifted  = '0;
      diff     = '0;
      for (int i = 0; i < DIV_BITS; i++) begin
         shifted  = {rem_next, quo_next[XLEN-1]};
         diff     = shifted - {1'b0, dsr};
         quo_next = {quo_next[XLEN-2:0], !diff[XLEN]};
         rem_next = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         count <= '0;
      end else if (rdy) begin
         if (start) begin
            quo   <= dividend;
            rem   <= '0;
            dsr   <= divisor;
            count <= CW'(ITERS);
         end else if (count != '0) begin
            quo   <= quo_next;
            rem   <= rem_next;
            count <= count - 1'b1;
         end
      end
   end

   assign last      = (count == CW'(1));
   assign quotient  = quo;
   assign remainder = rem;

endmodule

// File: rtl/mul_div_unit.sv
// RV32M execution unit: pipelined multiplier plus iterative divider behind a
// single issue port, broadcasting one-cycle result pulses on the CDB.
module mul_div_unit
   import mul_div_unit_pkg::*;
#(
   parameter int XLEN       = 32,
   parameter int ROB_POS_W  = 4,
   parameter int MUL_STAGES = 2,
   parameter int DIV_BITS   = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rdy,
   input  logic                 rollback,
   input  logic                 issue_valid,
   output logic                 issue_ready,
   input  logic [2:0]           funct3,
   input  logic [XLEN-1:0]      val1,
   input  logic [XLEN-1:0]      val2,
   input  logic [ROB_POS_W-1:0] rob_pos,
   output logic                 result,
   output logic [ROB_POS_W-1:0] result_rob_pos,
   output logic [XLEN-1:0]      result_val
);

   localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

   div_state_t state, state_next;

   logic [MUL_STAGES-1:0] mul_valid;
   logic [ROB_POS_W-1:0]  mul_rob  [MUL_STAGES];
   logic [2:0]            mul_f3   [MUL_STAGES];
   logic [2*XLEN-1:0]     mul_prod [MUL_STAGES];

   logic                   accept, accept_mul, accept_div;
   logic                   op_signed, div_zero, div_ovf, special;
   logic                   a_sign, b_sign;
   logic signed [2*XLEN-1:0] mul_a, mul_b, mul_full;
   logic [XLEN-1:0]        spec_in, abs1, abs2;

   logic                   div_special, div_rem, q_neg, r_neg, iter_last;
   logic [ROB_POS_W-1:0]   div_rob;
   logic [XLEN-1:0]        div_spec_val, div_quo, div_remv, quo_fix, rem_fix;

   // A divide may only start once the multiplier has fully drained, so the
   // two result sources can never present in the same cycle.
   assign issue_ready = rdy && !rollback && (state == DIV_IDLE) &&
                        (!is_div_op(funct3) || (mul_valid == '0));
   assign accept      = issue_valid && issue_ready && !rst;
   assign accept_mul  = accept && !is_div_op(funct3);
   assign accept_div  = accept && is_div_op(funct3);

   assign a_sign   = (funct3 != FUNCT3_MULHU) && val1[XLEN-1];
   assign b_sign   = ((funct3 == FUNCT3_MUL) || (funct3 == FUNCT3_MULH)) && val2[XLEN-1];
   assign mul_a    = {{XLEN{a_sign}}, val1};
   assign mul_b    = {{XLEN{b_sign}}, val2};
   assign mul_full = mul_a * mul_b;

   assign op_signed = is_signed_div(funct3);
   assign div_zero  = (val2 == '0);
   assign div_ovf   = op_signed && (val1 == INT_MIN) && (val2 == '1);
   assign special   = div_zero || div_ovf;
   assign spec_in   = div_zero ? (is_rem_op(funct3) ? val1 : '1)
                               : (is_rem_op(funct3) ? '0 : val1);
   assign abs1      = (op_signed && val1[XLEN-1]) ? -val1 : val1;
   assign abs2      = (op_signed && val2[XLEN-1]) ? -val2 : val2;

   always_ff @(posedge clk) begin
      if (rst || rollback) begin
         mul_valid <= '0;
      end else if (rdy) begin
         mul_valid[0] <= accept_mul;
         mul_rob[0]   <= rob_pos;
         mul_f3[0]    <= funct3;
         mul_prod[0]  <= mul_full;
         for (int i = 1; i < MUL_STAGES; i++) begin
            mul_valid[i] <= mul_valid[i-1];
            mul_rob[i]   <= mul_rob[i-1];
            mul_f3[i]    <= mul_f3[i-1];
            mul_prod[i]  <= mul_prod[i-1];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rdy && accept_div) begin
         div_rob      <= rob_pos;
         div_rem      <= is_rem_op(funct3);
         div_special  <= special;
         div_spec_val <= spec_in;
         q_neg        <= op_signed && (val1[XLEN-1] ^ val2[XLEN-1]);
         r_neg        <= op_signed && val1[XLEN-1];
      end
   end

   div_iter #(
      .XLEN     (XLEN),
      .DIV_BITS (DIV_BITS)
   ) u_div_iter (
      .clk       (clk),
      .rst       (rst),
      .rdy       (rdy),
      .flush     (rollback),
      .start     (accept_div && !special),
      .dividend  (abs1),
      .divisor   (abs2),
      .last      (iter_last),
      .quotient  (div_quo),
      .remainder (div_remv)
   );

   always_ff @(posedge clk) begin
      if (rst || rollback) begin
         state <= DIV_IDLE;
      end else if (rdy) begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         DIV_IDLE: if (accept_div) state_next = special ? DIV_DONE : DIV_RUN;
         DIV_RUN:  if (iter_last) state_next = DIV_DONE;
         DIV_DONE: state_next = DIV_IDLE;
         default:  state_next = DIV_IDLE;
      endcase
   end

   assign quo_fix = q_neg ? -div_quo : div_quo;
   assign rem_fix = r_neg ? -div_remv : div_remv;

   always_comb begin
      result         = 1'b0;
      result_rob_pos = '0;
      result_val     = '0;
      if (mul_valid[MUL_STAGES-1]) begin
         result         = 1'b1;
         result_rob_pos = mul_rob[MUL_STAGES-1];
         result_val     = (mul_f3[MUL_STAGES-1] == FUNCT3_MUL) ?
                          mul_prod[MUL_STAGES-1][XLEN-1:0] :
                          mul_prod[MUL_STAGES-1][2*XLEN-1:XLEN];
      end else if (state == DIV_DONE) begin
         result         = 1'b1;
         result_rob_pos = div_rob;
         result_val     = div_special ? div_spec_val : (div_rem ? rem_fix : quo_fix);
      end
   end

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: directed RV32M cases, rollback and stall
// scenarios, then randomized ops checked against an arithmetic reference model.
module tb_mul_div_unit;
   import mul_div_unit_pkg::*;

   localparam int XLEN       = 32;
   localparam int ROB_POS_W  = 4;
   localparam int MUL_STAGES = 2;
   localparam int DIV_BITS   = 1;

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic                 rdy = 1'b1;
   logic                 rollback = 1'b0;
   logic                 issue_valid = 1'b0;
   logic                 issue_ready;
   logic [2:0]           funct3 = '0;
   logic [XLEN-1:0]      val1 = '0;
   logic [XLEN-1:0]      val2 = '0;
   logic [ROB_POS_W-1:0] rob_pos = '0;
   logic                 result;
   logic [ROB_POS_W-1:0] result_rob_pos;
   logic [XLEN-1:0]      result_val;

   mul_div_unit #(
      .XLEN       (XLEN),
      .ROB_POS_W  (ROB_POS_W),
      .MUL_STAGES (MUL_STAGES),
      .DIV_BITS   (DIV_BITS)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .rdy            (rdy),
      .rollback       (rollback),
      .issue_valid    (issue_valid),
      .issue_ready    (issue_ready),
      .funct3         (funct3),
      .val1           (val1),
      .val2           (val2),
      .rob_pos        (rob_pos),
      .result         (result),
      .result_rob_pos (result_rob_pos),
      .result_val     (result_val)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [ROB_POS_W-1:0] rob;
      logic [XLEN-1:0]      val;
      int                   accept;
      int                   lat;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   failures = 0;
   int   rdy_edges = 0;
   logic [ROB_POS_W-1:0] next_rob = '0;

   // Latency is measured in enabled edges, so stalls shift results naturally.
   always @(posedge clk) if (rdy) rdy_edges <= rdy_edges + 1;

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   function automatic logic [XLEN-1:0] refModel(input logic [2:0] f3, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
      longint sa, sb, ua, ub, p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = longint'(a);
      ub = longint'(b);
      p  = 0;
      case (f3)
         FUNCT3_MUL:    p = sa * sb;
         FUNCT3_MULH:   begin p = sa * sb; p = p >>> 32; end
         FUNCT3_MULHSU: begin p = sa * ub; p = p >>> 32; end
         FUNCT3_MULHU:  begin p = ua * ub; p = p >> 32; end
         FUNCT3_DIV:    p = (b == 0) ? -1 : sa / sb;
         FUNCT3_DIVU:   p = (b == 0) ? -1 : ua / ub;
         FUNCT3_REM:    p = (b == 0) ? sa : sa % sb;
         default:       p = (b == 0) ? ua : ua % ub;
      endcase
      return p[XLEN-1:0];
   endfunction

   function automatic int latencyOf(input logic [2:0] f3, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
      if (!f3[2]) return MUL_STAGES;
      if (b == 0) return 1;
      if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
      return XLEN / DIV_BITS + 1;
   endfunction

   // Called at posedge+1; returns at posedge+1 after the accept edge.
   task automatic applyStimulus(input logic [2:0] f3, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                                input logic [XLEN-1:0] expv, output int waited);
      exp_t e;
      issue_valid = 1'b1;
      funct3 = f3;
      val1 = a;
      val2 = b;
      rob_pos = next_rob;
      waited = 0;
      @(negedge clk);
      while (!issue_ready && waited < 300) begin
         waited++;
         @(negedge clk);
      end
      if (!issue_ready) begin
         checkOutput("issue_timeout", 64'(waited), 64'(0));
         @(posedge clk);
         #1 issue_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      e.rob = next_rob;
      e.val = expv;
      e.accept = rdy_edges;
      e.lat = latencyOf(f3, a, b);
      sb.push_back(e);
      next_rob = next_rob + 1'b1;
      issue_valid = 1'b0;
   endtask

   task automatic waitDrain();
      for (int i = 0; i < 300 && sb.size() != 0; i++) @(posedge clk);
      #1 checkOutput("drain", 64'(sb.size()), 64'(0));
   endtask

   // Monitor: pops the scoreboard on every enabled result pulse.
   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         checkOutput("exclusive", 64'(dut.mul_valid[MUL_STAGES-1] && dut.state == DIV_DONE), 64'(0));
         if (result === 1'b1 && rdy) begin
            if (sb.size() == 0) begin
               checkOutput("unexpected_result", 64'(result_rob_pos), 64'hFFFF);
            end else begin
               e = sb.pop_front();
               checkOutput("rob_pos", 64'(result_rob_pos), 64'(e.rob));
               checkOutput("value", 64'(result_val), 64'(e.val));
               checkOutput("latency", 64'(rdy_edges - e.accept), 64'(e.lat - 1));
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int w;
      logic [2:0] f3;
      logic [XLEN-1:0] a, b;

      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      checkOutput("reset_result", 64'(result), 64'(0));
      checkOutput("reset_rob", 64'(result_rob_pos), 64'(0));
      checkOutput("reset_val", 64'(result_val), 64'(0));
      checkOutput("reset_ready", 64'(issue_ready), 64'(rdy));
      @(posedge clk);
      #1;

      next_rob = 4'd3;
      applyStimulus(FUNCT3_MUL,    32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, w);
      applyStimulus(FUNCT3_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, w);
      applyStimulus(FUNCT3_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, w);
      applyStimulus(FUNCT3_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, w);
      waitDrain();

      next_rob = 4'd0;
      for (int i = 0; i < 4; i++)
         applyStimulus(FUNCT3_MUL, 32'(i + 2), 32'd1000, 32'((i + 2) * 1000), w);
      applyStimulus(FUNCT3_DIV, -32'd7, 32'd2, 32'hFFFF_FFFD, w);
      checkOutput("div_wait_drain", 64'(w), 64'(MUL_STAGES));
      applyStimulus(FUNCT3_REM,  -32'd7,         32'd2,         32'hFFFF_FFFF, w);
      applyStimulus(FUNCT3_DIVU, 32'd100,        32'd7,         32'd14,        w);
      applyStimulus(FUNCT3_DIVU, 32'd5,          32'd0,         32'hFFFF_FFFF, w);
      applyStimulus(FUNCT3_REMU, 32'd5,          32'd0,         32'd5,         w);
      applyStimulus(FUNCT3_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, w);
      applyStimulus(FUNCT3_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         w);
      waitDrain();

      applyStimulus(FUNCT3_DIVU, 32'd1000, 32'd3, 32'd333, w);
      repeat (9) @(posedge clk);
      #1 rollback = 1'b1;
      @(posedge clk);
      #1 rollback = 1'b0;
      sb.delete();
      @(negedge clk);
      checkOutput("ready_after_rollback", 64'(issue_ready), 64'(1));
      @(posedge clk);
      #1;
      applyStimulus(FUNCT3_MUL, 32'd12, 32'd12, 32'd144, w);
      waitDrain();

      applyStimulus(FUNCT3_REM, -32'd1000, 32'd7, -32'd6, w);
      repeat (9) @(posedge clk);
      #1 rdy = 1'b0;
      repeat (5) @(posedge clk);
      #1 rdy = 1'b1;
      waitDrain();

      for (int n = 0; n < 150; n++) begin
         f3 = 3'($urandom_range(0, 7));
         case ($urandom_range(0, 7))
            0: a = '0;
            1: a = '1;
            2: a = 32'h8000_0000;
            default: a = $urandom;
         endcase
         case ($urandom_range(0, 7))
            0: b = '0;
            1: b = '1;
            2: b = 32'(($urandom_range(1, 15)));
            default: b = $urandom;
         endcase
         applyStimulus(f3, a, b, refModel(f3, a, b), w);
         if ($urandom_range(0, 7) == 0) begin
            rdy = 1'b0;
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1 rdy = 1'b1;
         end
      end
      waitDrain();

      repeat (3) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

RV32M execution unit: a pipelined multiplier and an iterative divider behind one issue port, fed by the reservation station. It broadcasts results on the common data bus in the same single-cycle pulse format as the integer ALU. Multiply latency and divide throughput are set by parameters. Rollback flushes all in-flight work.

## Interface
- XLEN, 32: operand and result width.
- ROB_POS_W, 4: ROB index width.
- MUL_STAGES, 2: multiplier pipeline depth (cycles, ≥1).
- DIV_BITS, 1: quotient bits retired per divide cycle. Legal values are 1, 2 and 4; XLEN must be divisible by DIV_BITS.

- clk  in  1  clock.
- rst  in  1  reset: synchronous, active-high.
- rdy  in  1  global enable; low freezes all state.
- rollback  in  1  flush all in-flight operations.
- issue_valid  in  1  reservation station offers an op.
- issue_ready  out  1  combinational; op accepted at an edge where issue_valid && issue_ready.
- funct3  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- val1, val2  in  XLEN  rs1 and rs2 operands.
- rob_pos  in  ROB_POS_W  destination ROB entry.
- result  out  1  one-cycle broadcast pulse.
- result_rob_pos  out  ROB_POS_W  ROB entry of the result.
- result_val  out  XLEN  result data.

## Operation
- Multiply path:
  - Each of MUL_STAGES stages holds valid, rob_pos and funct3; a new op may enter every cycle.
  - Operands are sign- or zero-extended to XLEN+1 bits per funct3. MULHSU: val1 signed, val2 unsigned.
  - The product is 2·XLEN bits. MUL returns the low XLEN bits; the other multiply ops return the high XLEN bits.
- Divide path FSM:
  - IDLE → RUN on accepting a normal divide.
  - IDLE → DONE on accepting a special case.
  - RUN → DONE after XLEN/DIV_BITS iterations.
  - DONE → IDLE after one cycle, during which the result is presented.
- Divide datapath:
  - On accept, latch |val1| and |val2| for signed ops and record the quotient and remainder signs.
  - RUN performs DIV_BITS restoring steps per cycle.
  - DONE applies the sign fixup: quotient negated if operand signs differ; remainder takes the sign of the dividend.
- Divide special cases (no iteration):
  - Divide by zero: quotient all-ones, remainder = val1.
  - Signed overflow (val1 = 0x80000000, val2 = -1): quotient = val1, remainder 0.
- Issue rule (guarantees no result collision):
  - issue_ready = rdy && !rollback && div FSM in IDLE.
  - In addition, a divide requires the multiply pipeline to be empty, or to empty by the cycle its result would be presented.
  - Simplest compliant rule, and the decided one: a divide is accepted only when all multiply stages are invalid. A multiply is accepted whenever the FSM is IDLE.
- Result selection: the multiply last-stage output and divide DONE are mutually exclusive by construction. The bench asserts this.
- rst or rollback at an edge:
  - All stage valids are cleared and the FSM goes to IDLE.
  - result, result_rob_pos and result_val are all set to 0.
  - Any op presented in that cycle is discarded.
- rdy low: no state changes, outputs hold their values, nothing is accepted. Consumers qualify result with rdy.

## Timing
- Reset values: result 0, result_rob_pos 0, result_val 0, FSM IDLE, all stage valids 0. After reset, issue_ready = rdy.
- Multiply latency: accepted at edge N → result high during the cycle after edge N+MUL_STAGES−1 (MUL_STAGES edges). Throughput is 1 per cycle.
- Normal divide: result pulse after XLEN/DIV_BITS+1 edges (33 with the defaults). issue_ready is low from the accept edge until the edge that leaves DONE.
- Special-case divide: result pulse after 1 edge.
- Each rdy-low cycle adds exactly one cycle to the latency of every in-flight op.
- result stays high for exactly one rdy-high cycle per op.

## Structure
- RV32M funct3 codes (FUNCT3_MUL … FUNCT3_REMU) are added to the shared macros header. The width macros are reused from the same header.
- Sub-module div_iter holds the unsigned restoring divider datapath: start, DIV_BITS steps per cycle, done, quotient and remainder.
- The multiplier pipeline, sign handling, FSM and result mux stay in mul_div_unit.

## Test plan
- MUL 7 × 0xFFFFFFFD (rob_pos 3) → result_val 0xFFFFFFEB, result_rob_pos 3, exactly MUL_STAGES edges after accept.
- MULH 0x80000000×0x80000000 → 0x40000000; MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE; MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF.
- Four back-to-back MULs with rob_pos 0–3 → four consecutive result pulses in order. A DIV offered meanwhile gets issue_ready low until the pipeline drains.
- DIV −7/2 → 0xFFFFFFFD; REM −7/2 → 0xFFFFFFFF; DIVU 100/7 → 14. Latency is 33 edges with DIV_BITS=1 and 9 edges with DIV_BITS=4.
- Special cases: DIVU 5/0 → 0xFFFFFFFF; REMU 5/0 → 5; DIV 0x80000000/−1 → 0x80000000; REM of the same → 0. Latency 1 edge.
- Rollback 10 cycles into a divide → no result pulse and issue_ready high next cycle; a following MUL completes normally. rdy held low 5 cycles mid-divide → the result pulse arrives 5 cycles later with the correct value.
